// File: rtl/hr_pkg.sv
// Shared flit-format helpers for the hierarchical-ring bridge.
// Flits are zero-extended to MAX_FLIT_W so one set of helpers serves every flit width.
package hr_pkg;

   localparam int MAX_FLIT_W = 1024;
   localparam int IDX_W      = $clog2(MAX_FLIT_W);
   localparam int MAX_RID_W  = 32;
   localparam int RID_LSB    = 0;

   function automatic logic [IDX_W-1:0] valid_bit(input int flit_w);
      return IDX_W'(flit_w - 1);
   endfunction

   function automatic logic is_valid(input logic [MAX_FLIT_W-1:0] flit,
                                     input logic [IDX_W-1:0]      vbit);
      return flit[vbit];
   endfunction

   function automatic logic [MAX_RID_W-1:0] rid_of(input logic [MAX_FLIT_W-1:0] flit);
      return flit[RID_LSB +: MAX_RID_W];
   endfunction

endpackage

// File: rtl/hr_bridge_fifo.sv
// Circular transfer FIFO between the two rings; head is the oldest entry.
// A push while full and a pop while empty are ignored.
module hr_bridge_fifo
   import hr_pkg::*;
#(
   parameter int WIDTH = 144,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hr_bridge_param.sv
// Local/global ring junction: per lane, one FIFO each way; full FIFOs deflect flits
// back onto their ring and bump a saturating counter.
module hr_bridge_param
   import hr_pkg::*;
#(
   parameter int FLIT_W    = 144,
   parameter int RID_W     = 4,
   parameter int LOCAL_RID = 0,
   parameter int NUM_CH    = 2,
   parameter int DEPTH     = 4,
   parameter int DCNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*FLIT_W-1:0] local_i,
   output logic [NUM_CH*FLIT_W-1:0] local_o,
   input  logic [NUM_CH*FLIT_W-1:0] global_i,
   output logic [NUM_CH*FLIT_W-1:0] global_o,
   output logic [NUM_CH-1:0]        enq_l2g_o,
   output logic [NUM_CH-1:0]        enq_g2l_o,
   output logic [NUM_CH-1:0]        deq_l2g_o,
   output logic [NUM_CH-1:0]        deq_g2l_o,
   output logic [NUM_CH-1:0]        full_l2g_o,
   output logic [NUM_CH-1:0]        full_g2l_o,
   output logic [NUM_CH*DCNT_W-1:0] defl_l2g_o,
   output logic [NUM_CH*DCNT_W-1:0] defl_g2l_o
);

   localparam logic [IDX_W-1:0] VBIT   = valid_bit(FLIT_W);
   localparam logic [RID_W-1:0] MY_RID = RID_W'(LOCAL_RID);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      logic [FLIT_W-1:0] l_in;
      logic [FLIT_W-1:0] g_in;
      logic [FLIT_W-1:0] l2g_head;
      logic [FLIT_W-1:0] g2l_head;
      logic              l_valid;
      logic              g_valid;
      logic              l_mine;
      logic              g_mine;
      logic              l2g_full;
      logic              l2g_empty;
      logic              g2l_full;
      logic              g2l_empty;
      logic              l2g_push;
      logic              l2g_pop;
      logic              g2l_push;
      logic              g2l_pop;
      logic              l2g_defl;
      logic              g2l_defl;
      logic [FLIT_W-1:0] local_q;
      logic [FLIT_W-1:0] global_q;
      logic              enq_l2g_q;
      logic              enq_g2l_q;
      logic              deq_l2g_q;
      logic              deq_g2l_q;
      logic [DCNT_W-1:0] defl_l2g_q;
      logic [DCNT_W-1:0] defl_g2l_q;

      assign l_in = local_i[c*FLIT_W +: FLIT_W];
      assign g_in = global_i[c*FLIT_W +: FLIT_W];

      // A slot is free for injection when it is empty or its flit is ejected this cycle.
      always_comb begin
         l_valid  = is_valid(MAX_FLIT_W'(l_in), VBIT);
         g_valid  = is_valid(MAX_FLIT_W'(g_in), VBIT);
         l_mine   = (RID_W'(rid_of(MAX_FLIT_W'(l_in))) == MY_RID);
         g_mine   = (RID_W'(rid_of(MAX_FLIT_W'(g_in))) == MY_RID);
         l2g_push = l_valid && !l_mine && !l2g_full;
         l2g_defl = l_valid && !l_mine && l2g_full;
         g2l_push = g_valid && g_mine && !g2l_full;
         g2l_defl = g_valid && g_mine && g2l_full;
         l2g_pop  = (!g_valid || g2l_push) && !l2g_empty;
         g2l_pop  = (!l_valid || l2g_push) && !g2l_empty;
      end

      hr_bridge_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_l2g (
         .clk   (clk),
         .rst   (rst),
         .push  (l2g_push),
         .pop   (l2g_pop),
         .din   (l_in),
         .head  (l2g_head),
         .full  (l2g_full),
         .empty (l2g_empty)
      );

      hr_bridge_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_g2l (
         .clk   (clk),
         .rst   (rst),
         .push  (g2l_push),
         .pop   (g2l_pop),
         .din   (g_in),
         .head  (g2l_head),
         .full  (g2l_full),
         .empty (g2l_empty)
      );

      // Invalid or ejected slots leave as all-zero rather than carrying stale payload.
      always_ff @(posedge clk) begin
         if (rst) begin
            local_q    <= '0;
            global_q   <= '0;
            enq_l2g_q  <= 1'b0;
            enq_g2l_q  <= 1'b0;
            deq_l2g_q  <= 1'b0;
            deq_g2l_q  <= 1'b0;
            defl_l2g_q <= '0;
            defl_g2l_q <= '0;
         end else begin
            local_q   <= g2l_pop ? g2l_head : ((l_valid && !l2g_push) ? l_in : '0);
            global_q  <= l2g_pop ? l2g_head : ((g_valid && !g2l_push) ? g_in : '0);
            enq_l2g_q <= l2g_push;
            enq_g2l_q <= g2l_push;
            deq_l2g_q <= l2g_pop;
            deq_g2l_q <= g2l_pop;
            if (l2g_defl && (defl_l2g_q != '1)) begin
               defl_l2g_q <= defl_l2g_q + DCNT_W'(1);
            end
            if (g2l_defl && (defl_g2l_q != '1)) begin
               defl_g2l_q <= defl_g2l_q + DCNT_W'(1);
            end
         end
      end

      assign local_o[c*FLIT_W +: FLIT_W]    = local_q;
      assign global_o[c*FLIT_W +: FLIT_W]   = global_q;
      assign enq_l2g_o[c]                   = enq_l2g_q;
      assign enq_g2l_o[c]                   = enq_g2l_q;
      assign deq_l2g_o[c]                   = deq_l2g_q;
      assign deq_g2l_o[c]                   = deq_g2l_q;
      assign full_l2g_o[c]                  = l2g_full;
      assign full_g2l_o[c]                  = g2l_full;
      assign defl_l2g_o[c*DCNT_W +: DCNT_W] = defl_l2g_q;
      assign defl_g2l_o[c*DCNT_W +: DCNT_W] = defl_g2l_q;
   end

endmodule
